// File: rtl/scope_pkg.sv
// Shared types and defaults for the scope acquisition controller.
package scope_pkg;

    localparam int ADDR_W       = 9;
    localparam int DEPTH_DEF    = 500;
    localparam int PRE_CNT_DEF  = 250;
    localparam int AUTO_TMO_DEF = 4096;

    localparam logic [1:0] MODE_AUTO   = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_SINGLE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_FILL  = 3'd1,
        ST_ARMED     = 3'd2,
        ST_POST_FILL = 3'd3,
        ST_HOLD      = 3'd4
    } acq_state_t;

endpackage

// File: rtl/acq_addr_ctr.sv
// Capture-buffer write address: increments per written sample and wraps
// from DEPTH-1 back to 0. A clear restarts the frame at address 0.
module acq_addr_ctr import scope_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              ad_clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] r_addr;

    // Wrap-around address register; clear wins over increment.
    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (clr) begin
            r_addr <= '0;
        end else if (inc) begin
            r_addr <= (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
        end
    end

    assign addr = r_addr;

endmodule

// File: rtl/scope_acq_ctrl.sv
// Oscilloscope acquisition sequencer: pre-fill, arm, trigger, post-fill,
// then hold the frame until the display has read it.
// Optional feature macro ACQ_AUTO_TRIG_EN: in AUTO mode, self-trigger after
// AUTO_TMO strobes spent armed. Without it AUTO behaves as NORMAL.
//
// state     | meaning
// IDLE      | stopped, buffer not written
// PRE_FILL  | collecting PRE_CNT pre-trigger samples
// ARMED     | writing, waiting for a trigger
// POST_FILL | writing the post-trigger part of the frame
// HOLD      | frame complete, frozen until disp_done
module scope_acq_ctrl import scope_pkg::*; #(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PRE_CNT  = PRE_CNT_DEF,
    parameter int AUTO_TMO = AUTO_TMO_DEF
) (
    input  logic              ad_clk,
    input  logic              rst,
    input  logic              deci_valid,
    input  logic              trig_pulse,
    input  logic [1:0]        mode,
    input  logic              run_req,
    input  logic              single_arm,
    input  logic              force_trig,
    input  logic              disp_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              frame_ready,
    output logic              auto_flag,
    output logic [2:0]        state
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CNT - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(DEPTH - PRE_CNT - 2);

    acq_state_t        r_state;
    logic [CNT_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]  r_post_cnt;
    logic [ADDR_W-1:0] r_trig_addr;
    logic              r_frame_ready;
    logic              r_auto_flag;

    logic w_fill;
    logic w_start;
    logic w_hold_exit;
    logic w_rearm;
    logic w_clr;
    logic w_hw_trig;
    logic w_tmo_trig;

    assign w_fill      = (r_state == ST_PRE_FILL) || (r_state == ST_ARMED) ||
                         (r_state == ST_POST_FILL);
    assign w_start     = (r_state == ST_IDLE) && run_req &&
                         ((mode != MODE_SINGLE) || single_arm);
    assign w_hold_exit = (r_state == ST_HOLD) && disp_done;
    assign w_rearm     = w_hold_exit && run_req && (mode != MODE_SINGLE);
    assign w_clr       = w_start || w_rearm;
    assign w_hw_trig   = deci_valid && trig_pulse;

    assign wr_en = deci_valid && w_fill;

    acq_addr_ctr #(.DEPTH(DEPTH)) u_addr (
        .ad_clk (ad_clk),
        .rst    (rst),
        .inc    (wr_en),
        .clr    (w_clr),
        .addr   (wr_addr)
    );

`ifdef ACQ_AUTO_TRIG_EN
    localparam int TMO_W = $clog2(AUTO_TMO + 1);

    logic [1:0]       r_mode;
    logic [TMO_W-1:0] r_tmo_cnt;

    // Mode is latched only when a capture begins; the timeout counter is
    // zeroed throughout PRE_FILL so every entry to ARMED starts from 0.
    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            r_mode    <= MODE_NORMAL;
            r_tmo_cnt <= '0;
        end else begin
            if (w_start || w_hold_exit) begin
                r_mode <= mode;
            end
            if (r_state == ST_PRE_FILL) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == ST_ARMED) && (r_mode == MODE_AUTO) && deci_valid) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    assign w_tmo_trig = (r_state == ST_ARMED) && (r_mode == MODE_AUTO) && deci_valid &&
                        (r_tmo_cnt == TMO_W'(AUTO_TMO - 1));
`else
    assign w_tmo_trig = 1'b0;
`endif

    // Acquisition state machine with registered status outputs.
    always_ff @(posedge ad_clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_trig_addr   <= '0;
            r_frame_ready <= 1'b0;
            r_auto_flag   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_PRE_FILL;
                        r_pre_cnt  <= '0;
                        r_post_cnt <= '0;
                    end
                end
                ST_PRE_FILL: begin
                    if (deci_valid) begin
                        r_pre_cnt <= r_pre_cnt + 1'b1;
                        if (r_pre_cnt == PRE_LAST) begin
                            r_state <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    // A real trigger outranks a manual or timeout trigger.
                    if (w_hw_trig) begin
                        r_trig_addr <= wr_addr;
                        r_auto_flag <= 1'b0;
                        r_post_cnt  <= '0;
                        r_state     <= ST_POST_FILL;
                    end else if (force_trig || w_tmo_trig) begin
                        r_trig_addr <= wr_addr;
                        r_auto_flag <= 1'b1;
                        r_post_cnt  <= '0;
                        r_state     <= ST_POST_FILL;
                    end
                end
                ST_POST_FILL: begin
                    if (deci_valid) begin
                        if (r_post_cnt == POST_LAST) begin
                            r_state       <= ST_HOLD;
                            r_frame_ready <= 1'b1;
                        end else begin
                            r_post_cnt <= r_post_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (disp_done) begin
                        r_frame_ready <= 1'b0;
                        if (w_rearm) begin
                            r_state    <= ST_PRE_FILL;
                            r_pre_cnt  <= '0;
                            r_post_cnt <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign trig_addr   = r_trig_addr;
    assign frame_ready = r_frame_ready;
    assign auto_flag   = r_auto_flag;
    assign state       = r_state;

endmodule

// File: tb/tb_scope_acq_ctrl.sv
// Self-checking bench for scope_acq_ctrl (default parameters).
// Expected frame results are queued when the trigger stimulus is chosen and
// compared when frame_ready appears.
module tb_scope_acq_ctrl;

    localparam int DEPTH = 500;

    logic       ad_clk = 1'b0;
    logic       rst;
    logic       deci_valid;
    logic       trig_pulse;
    logic [1:0] mode;
    logic       run_req;
    logic       single_arm;
    logic       force_trig;
    logic       disp_done;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [8:0] trig_addr;
    logic       frame_ready;
    logic       auto_flag;
    logic [2:0] state;

    typedef struct packed {
        int         rdy;
        logic [8:0] taddr;
        logic       af;
    } exp_t;

    exp_t sb[$];

    int   errors = 0;
    int   checks = 0;
    logic s_wr_en;
    logic [8:0] s_wr_addr;

    scope_acq_ctrl dut (
        .ad_clk      (ad_clk),
        .rst         (rst),
        .deci_valid  (deci_valid),
        .trig_pulse  (trig_pulse),
        .mode        (mode),
        .run_req     (run_req),
        .single_arm  (single_arm),
        .force_trig  (force_trig),
        .disp_done   (disp_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .trig_addr   (trig_addr),
        .frame_ready (frame_ready),
        .auto_flag   (auto_flag),
        .state       (state)
    );

    always #5 ad_clk = ~ad_clk;

    // One clock: apply inputs, sample combinational outputs mid-cycle,
    // return 1 time unit after the edge with pulses cleared.
    task automatic cyc(input logic dv, input logic tp, input logic ft,
                       input logic sa, input logic dd);
        deci_valid = dv; trig_pulse = tp; force_trig = ft;
        single_arm = sa; disp_done = dd;
        @(negedge ad_clk);
        s_wr_en   = wr_en;
        s_wr_addr = wr_addr;
        @(posedge ad_clk); #1;
        trig_pulse = 0; force_trig = 0; single_arm = 0; disp_done = 0;
    endtask

    task automatic apply_reset();
        rst = 1; deci_valid = 0; trig_pulse = 0; force_trig = 0;
        single_arm = 0; disp_done = 0; run_req = 0; mode = 2'd1;
        repeat (2) @(posedge ad_clk);
        #1 rst = 0;
    endtask

    // Strobe every cycle from strobe 0 (first PRE_FILL cycle); returns the
    // strobe on which frame_ready rose, and counts write-address deviations
    // from the ideal k mod DEPTH sequence.
    task automatic run_capture(input int ta, input int tb, input int fa, input int limit,
                               output int rdy, output logic [8:0] t_o, output logic a_o,
                               output int addr_dev, output bit to);
        rdy = -1; t_o = '0; a_o = 1'b0; addr_dev = 0; to = 1'b1;
        for (int k = 0; k < limit; k++) begin
            cyc(1'b1, (k == ta) || (k == tb), k == fa, 1'b0, 1'b0);
            if (s_wr_en !== 1'b1 || s_wr_addr !== 9'(k % DEPTH)) addr_dev++;
            if (frame_ready === 1'b1) begin
                rdy = k; t_o = trig_addr; a_o = auto_flag; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; deci_valid = 1; trig_pulse = 0; force_trig = 0;
        single_arm = 0; disp_done = 0; run_req = 1; mode = 2'd1;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        checks++; if (wr_addr !== 9'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        checks++; if (trig_addr !== 9'd0) begin errors++; $display("FAIL reset_trig_addr: got %0d want 0", trig_addr); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready: got %0b want 0", frame_ready); end
        checks++; if (auto_flag !== 1'b0) begin errors++; $display("FAIL reset_auto_flag: got %0b want 0", auto_flag); end
        apply_reset();
    endtask

    task automatic test_normal();
        int rdy, dev; logic [8:0] ta; logic af; bit to; exp_t e;
        apply_reset();
        mode = 2'd1; run_req = 1;
        cyc(0, 0, 0, 0, 0);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL normal_start: state %0d want 1", state); end
        sb.push_back('{rdy: 549, taddr: 9'd300, af: 1'b0});
        run_capture(300, -1, -1, 700, rdy, ta, af, dev, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL normal_timeout: no frame_ready within 700 strobes"); end
        checks++; if (rdy !== e.rdy) begin errors++; $display("FAIL normal_rdy: got %0d want %0d", rdy, e.rdy); end
        checks++; if (ta !== e.taddr) begin errors++; $display("FAIL normal_trig_addr: got %0d want %0d", ta, e.taddr); end
        checks++; if (af !== e.af) begin errors++; $display("FAIL normal_auto_flag: got %0b want %0b", af, e.af); end
        checks++; if (dev !== 0) begin errors++; $display("FAIL normal_wr_addr: %0d deviations want 0", dev); end
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL normal_hold: state %0d want 4", state); end
        cyc(1, 1, 0, 0, 0);
        checks++; if (s_wr_en !== 1'b0) begin errors++; $display("FAIL hold_wr_en: got %0b want 0", s_wr_en); end
        checks++; if (trig_addr !== 9'd300) begin errors++; $display("FAIL hold_trig_ignored: got %0d want 300", trig_addr); end
    endtask

    // Continues from the HOLD left by test_normal.
    task automatic test_back_to_back();
        int rdy, dev; logic [8:0] ta; logic af; bit to; exp_t e;
        cyc(0, 0, 0, 0, 1);
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL b2b_clear: frame_ready %0b want 0", frame_ready); end
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL b2b_rearm: state %0d want 1", state); end
        sb.push_back('{rdy: 509, taddr: 9'd260, af: 1'b0});
        run_capture(100, 260, -1, 700, rdy, ta, af, dev, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: no frame_ready within 700 strobes"); end
        checks++; if (rdy !== e.rdy) begin errors++; $display("FAIL b2b_rdy: got %0d want %0d", rdy, e.rdy); end
        checks++; if (ta !== e.taddr) begin errors++; $display("FAIL b2b_trig_addr: got %0d want %0d", ta, e.taddr); end
        checks++; if (dev !== 0) begin errors++; $display("FAIL b2b_wr_addr: %0d deviations want 0", dev); end
        run_req = 0;
        cyc(0, 0, 0, 0, 1);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL b2b_stop: state %0d want 0", state); end
    endtask

    task automatic test_auto();
        int rdy, dev; logic [8:0] ta; logic af; bit to; exp_t e;
        apply_reset();
        mode = 2'd0; run_req = 1;
        cyc(0, 0, 0, 0, 0);
`ifdef ACQ_AUTO_TRIG_EN
        sb.push_back('{rdy: 4594, taddr: 9'd345, af: 1'b1});
        run_capture(-1, -1, -1, 5000, rdy, ta, af, dev, to);
`else
        sb.push_back('{rdy: 849, taddr: 9'd100, af: 1'b1});
        run_capture(-1, -1, 600, 1200, rdy, ta, af, dev, to);
`endif
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL auto_timeout: no frame_ready within bound"); end
        checks++; if (rdy !== e.rdy) begin errors++; $display("FAIL auto_rdy: got %0d want %0d", rdy, e.rdy); end
        checks++; if (ta !== e.taddr) begin errors++; $display("FAIL auto_trig_addr: got %0d want %0d", ta, e.taddr); end
        checks++; if (af !== e.af) begin errors++; $display("FAIL auto_flag: got %0b want %0b", af, e.af); end
        run_req = 0;
        cyc(0, 0, 0, 0, 1);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL auto_stop: state %0d want 0", state); end
    endtask

    task automatic test_single();
        int rdy, dev, n_wr; logic [8:0] ta; logic af; bit to; exp_t e;
        apply_reset();
        mode = 2'd2; run_req = 1;
        n_wr = 0;
        repeat (5) begin cyc(1, 0, 0, 0, 0); if (s_wr_en === 1'b1) n_wr++; end
        checks++; if (state !== 3'd0 || n_wr !== 0) begin errors++; $display("FAIL single_wait: state %0d writes %0d want 0 0", state, n_wr); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL single_arm: state %0d want 1", state); end
        sb.push_back('{rdy: 649, taddr: 9'd400, af: 1'b0});
        run_capture(400, -1, -1, 800, rdy, ta, af, dev, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL single_timeout: no frame_ready within 800 strobes"); end
        checks++; if (rdy !== e.rdy) begin errors++; $display("FAIL single_rdy: got %0d want %0d", rdy, e.rdy); end
        checks++; if (ta !== e.taddr) begin errors++; $display("FAIL single_trig_addr: got %0d want %0d", ta, e.taddr); end
        cyc(0, 0, 0, 0, 1);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL single_done: state %0d want 0", state); end
        n_wr = 0;
        repeat (20) begin cyc(1, 0, 0, 0, 0); if (s_wr_en === 1'b1) n_wr++; end
        checks++; if (n_wr !== 0) begin errors++; $display("FAIL single_no_wr: writes %0d want 0", n_wr); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL single_rearm: state %0d want 1", state); end
    endtask

    task automatic test_coincident_wrap();
        int rdy, dev; logic [8:0] ta; logic af; bit to; exp_t e;
        apply_reset();
        mode = 2'd1; run_req = 1;
        cyc(0, 0, 0, 0, 0);
        run_req = 0;
        sb.push_back('{rdy: 729, taddr: 9'd480, af: 1'b0});
        run_capture(480, -1, 480, 900, rdy, ta, af, dev, to);
        e = sb.pop_front();
        checks++; if (to) begin errors++; $display("FAIL coin_timeout: no frame_ready within 900 strobes"); end
        checks++; if (rdy !== e.rdy) begin errors++; $display("FAIL coin_rdy: got %0d want %0d", rdy, e.rdy); end
        checks++; if (ta !== e.taddr) begin errors++; $display("FAIL coin_trig_addr: got %0d want %0d", ta, e.taddr); end
        checks++; if (af !== e.af) begin errors++; $display("FAIL coin_auto_flag: got %0b want %0b", af, e.af); end
        checks++; if (dev !== 0) begin errors++; $display("FAIL coin_wrap: %0d deviations want 0", dev); end
        checks++; if (wr_addr !== 9'd230) begin errors++; $display("FAIL coin_wr_addr: got %0d want 230", wr_addr); end
        cyc(0, 0, 0, 0, 1);
        checks++; if (state !== 3'd0 || frame_ready !== 1'b0) begin errors++; $display("FAIL coin_stop: state %0d ready %0b want 0 0", state, frame_ready); end
    endtask

    task automatic test_reset_mid_capture();
        int rdy, dev, n_rdy; logic [8:0] ta; logic af; bit to;
        apply_reset();
        mode = 2'd1; run_req = 1;
        cyc(0, 0, 0, 0, 0);
        run_capture(300, -1, -1, 400, rdy, ta, af, dev, to);
        checks++; if (!to) begin errors++; $display("FAIL mid_early_ready: frame_ready at strobe %0d", rdy); end
        checks++; if (state !== 3'd3 || trig_addr !== 9'd300) begin errors++; $display("FAIL mid_post_fill: state %0d trig %0d want 3 300", state, trig_addr); end
        deci_valid = 1;
        #2 rst = 1;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", state); end
        checks++; if (wr_addr !== 9'd0 || trig_addr !== 9'd0) begin errors++; $display("FAIL mid_addrs: wr %0d trig %0d want 0 0", wr_addr, trig_addr); end
        checks++; if (wr_en !== 1'b0 || frame_ready !== 1'b0 || auto_flag !== 1'b0) begin errors++; $display("FAIL mid_flags: wr_en %0b ready %0b auto %0b want 0 0 0", wr_en, frame_ready, auto_flag); end
        @(posedge ad_clk); #1;
        rst = 0; run_req = 0;
        n_rdy = 0;
        repeat (300) begin cyc(1, 1, 0, 0, 0); if (frame_ready === 1'b1) n_rdy++; end
        checks++; if (n_rdy !== 0 || state !== 3'd0) begin errors++; $display("FAIL mid_no_frame: ready cycles %0d state %0d want 0 0", n_rdy, state); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_to_back();
        test_auto();
        test_single();
        test_coincident_wrap();
        test_reset_mid_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
